// File: rtl/nv_pwr_pkg.sv
// Shared definitions for the island power-gate sequencer.
//   state_t        : sequencer state encoding (4 bits, 10 states)
//   stage_idx_w()  : width of the stage index for a given stage count
//   ISO_DLY_DEF    : default isolation / clock-enable spacing in cycles
//   TIMEOUT_DEF    : default per-stage ack timeout in cycles
package nv_pwr_pkg;

    typedef enum logic [3:0] {
        ST_OFF     = 4'd0,
        ST_UP_STG  = 4'd1,
        ST_UP_WAIT = 4'd2,
        ST_CLK_ON  = 4'd3,
        ST_ISO_REL = 4'd4,
        ST_ON      = 4'd5,
        ST_ISO_SET = 4'd6,
        ST_CLK_OFF = 4'd7,
        ST_DN_STG  = 4'd8,
        ST_FAULT   = 4'd9
    } state_t;

    localparam int ISO_DLY_DEF = 4;
    localparam int TIMEOUT_DEF = 255;

    // Index needs at least one bit even for a two-stage chain.
    function automatic int stage_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nv_pwr_dly_cnt.sv
// Loadable down-counter used for stage delays, iso/clock spacing and the
// ack timeout. Loading value N makes done rise N clocks later (N=0: done
// is already high on the next cycle). Holds at zero, never wraps.
//   clk      : clock
//   rst      : asynchronous active-high reset (count cleared)
//   load     : load load_val on the next edge (takes priority)
//   load_val : value to load
//   done     : count is zero
module nv_pwr_dly_cnt
    import nv_pwr_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/nv_pwr_gate_seq.sv
// Power-gate sequencer for one switchable island. Steps a daisy chain of
// power-switch enables on, then enables the island clock and releases
// isolation; reverses the order on power-down. Level req/ack handshake
// with the PMU, per-stage ack timeout and a sticky fault.
//   nvdla_core_clk : block clock
//   nvdla_core_rst : asynchronous active-high reset
//   pwr_req        : 1 = island requested on, 0 = requested off
//   pwr_ack        : 1 only while island is fully on and de-isolated
//   cfg_stage_dly  : cycles between stage enables (0 behaves as 1)
//   pg_en          : thermometer-coded switch stage enables
//   pg_ack         : per-stage switch acknowledge (pre-synchronised)
//   iso_en         : island output isolation (1 = isolated)
//   clk_en         : island clock enable
//   busy           : sequence in progress
//   fault          : sticky ack timeout, cleared only by reset
//
// state      | meaning
// -----------+--------------------------------------------------------
// OFF        | island off, isolated, waiting for pwr_req=1
// UP_STG     | pg_en[k] just raised, counting stage delay
// UP_WAIT    | stage delay over, waiting for pg_ack[k] (timeout armed)
// CLK_ON     | all switches on, clk_en=1, counting ISO_DLY
// ISO_REL    | isolation released, counting ISO_DLY
// ON         | island on, pwr_ack=1, waiting for pwr_req=0
// ISO_SET    | isolation re-applied, counting ISO_DLY
// CLK_OFF    | clock gated, counting ISO_DLY
// DN_STG     | pg_en[k] just cleared, counting stage delay
// FAULT      | ack timeout; switches held, exit by reset only
module nv_pwr_gate_seq
    import nv_pwr_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int DLY_W      = 8,
    parameter int ISO_DLY    = ISO_DLY_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rst,
    input  logic                  pwr_req,
    output logic                  pwr_ack,
    input  logic [DLY_W-1:0]      cfg_stage_dly,
    output logic [NUM_STAGES-1:0] pg_en,
    input  logic [NUM_STAGES-1:0] pg_ack,
    output logic                  iso_en,
    output logic                  clk_en,
    output logic                  busy,
    output logic                  fault
);

    localparam int K_W   = stage_idx_w(NUM_STAGES);
    localparam int ISO_W = $clog2(ISO_DLY + 1);
    localparam int CNT_W = (DLY_W > ISO_W) ? DLY_W : ISO_W;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [K_W-1:0]   K_LAST = K_W'(NUM_STAGES - 1);
    localparam logic [CNT_W-1:0] ISO_M1 = CNT_W'(ISO_DLY - 1);
    localparam logic [TO_W-1:0]  TO_M1  = TO_W'(TIMEOUT - 1);

    state_t           state;
    logic [K_W-1:0]   k;
    logic [DLY_W-1:0] dly_reg;
    logic [DLY_W-1:0] cfg_eff;
    logic [CNT_W-1:0] cfg_m1;
    logic [CNT_W-1:0] dly_m1;
    logic [CNT_W-1:0] dly_val;
    logic             dly_load;
    logic             dly_done;
    logic             to_load;
    logic             to_done;

    assign cfg_eff = (cfg_stage_dly == '0) ? DLY_W'(1) : cfg_stage_dly;
    assign cfg_m1  = CNT_W'(cfg_eff - DLY_W'(1));
    assign dly_m1  = CNT_W'(dly_reg - DLY_W'(1));

    // Counters are loaded with (delay-1) on the same edge the FSM enters
    // the timed state, so the state lasts exactly 'delay' cycles.
    always_comb begin
        dly_load = 1'b0;
        dly_val  = '0;
        to_load  = 1'b0;
        case (state)
            ST_OFF: begin
                if (pwr_req) begin
                    dly_load = 1'b1;
                    dly_val  = cfg_m1;
                end
            end
            ST_UP_STG: begin
                to_load = dly_done;
            end
            ST_UP_WAIT: begin
                if (pg_ack[k]) begin
                    dly_load = 1'b1;
                    dly_val  = (k == K_LAST) ? ISO_M1 : dly_m1;
                end
            end
            ST_CLK_ON, ST_ISO_SET: begin
                if (dly_done) begin
                    dly_load = 1'b1;
                    dly_val  = ISO_M1;
                end
            end
            ST_ON: begin
                if (!pwr_req) begin
                    dly_load = 1'b1;
                    dly_val  = ISO_M1;
                end
            end
            ST_CLK_OFF: begin
                if (dly_done) begin
                    dly_load = 1'b1;
                    dly_val  = dly_m1;
                end
            end
            ST_DN_STG: begin
                if (dly_done && (k != '0)) begin
                    dly_load = 1'b1;
                    dly_val  = dly_m1;
                end
            end
            default: ;
        endcase
    end

    nv_pwr_dly_cnt #(.W(CNT_W)) u_dly_cnt (
        .clk      (nvdla_core_clk),
        .rst      (nvdla_core_rst),
        .load     (dly_load),
        .load_val (dly_val),
        .done     (dly_done)
    );

    nv_pwr_dly_cnt #(.W(TO_W)) u_to_cnt (
        .clk      (nvdla_core_clk),
        .rst      (nvdla_core_rst),
        .load     (to_load),
        .load_val (TO_M1),
        .done     (to_done)
    );

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state   <= ST_OFF;
            k       <= '0;
            dly_reg <= DLY_W'(1);
            pg_en   <= '0;
            iso_en  <= 1'b1;
            clk_en  <= 1'b0;
            pwr_ack <= 1'b0;
            busy    <= 1'b0;
            fault   <= 1'b0;
        end else begin
            case (state)
                ST_OFF: begin
                    if (pwr_req) begin
                        state   <= ST_UP_STG;
                        k       <= '0;
                        dly_reg <= cfg_eff;
                        pg_en   <= {pg_en[NUM_STAGES-2:0], 1'b1};
                        busy    <= 1'b1;
                    end
                end
                ST_UP_STG: begin
                    if (dly_done) begin
                        state <= ST_UP_WAIT;
                    end
                end
                ST_UP_WAIT: begin
                    if (pg_ack[k]) begin
                        if (k == K_LAST) begin
                            state  <= ST_CLK_ON;
                            clk_en <= 1'b1;
                        end else begin
                            state <= ST_UP_STG;
                            k     <= k + K_W'(1);
                            pg_en <= {pg_en[NUM_STAGES-2:0], 1'b1};
                        end
                    end else if (to_done) begin
                        state  <= ST_FAULT;
                        fault  <= 1'b1;
                        busy   <= 1'b0;
                        clk_en <= 1'b0;
                        iso_en <= 1'b1;
                    end
                end
                ST_CLK_ON: begin
                    if (dly_done) begin
                        state  <= ST_ISO_REL;
                        iso_en <= 1'b0;
                    end
                end
                ST_ISO_REL: begin
                    if (dly_done) begin
                        state   <= ST_ON;
                        pwr_ack <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                ST_ON: begin
                    if (!pwr_req) begin
                        state   <= ST_ISO_SET;
                        dly_reg <= cfg_eff;
                        pwr_ack <= 1'b0;
                        iso_en  <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                ST_ISO_SET: begin
                    if (dly_done) begin
                        state  <= ST_CLK_OFF;
                        clk_en <= 1'b0;
                    end
                end
                ST_CLK_OFF: begin
                    if (dly_done) begin
                        state <= ST_DN_STG;
                        k     <= K_LAST;
                        pg_en <= pg_en >> 1;
                    end
                end
                ST_DN_STG: begin
                    // Switch acks are not monitored on the way down.
                    if (dly_done) begin
                        if (k != '0) begin
                            k     <= k - K_W'(1);
                            pg_en <= pg_en >> 1;
                        end else begin
                            state <= ST_OFF;
                            busy  <= 1'b0;
                        end
                    end
                end
                ST_FAULT: ;
                default: begin
                    state <= ST_OFF;
                end
            endcase
        end
    end

endmodule

// File: doc/nv_pwr_gate_seq.md
Name: nv_pwr_gate_seq

Overview:
- Power-gate sequencer for one switchable island, e.g. a CBUF RAM bank or a MAC cell group.
- Drives a daisy chain of power-switch enables in stages. Each stage output goes through an always-on 2-input AND cell: stage k enable is ANDed with the ack of stage k-1.
- Controls island clock enable and output isolation.
- Gives the power-management unit a level request/acknowledge handshake, with a configurable inter-stage delay, an ack timeout and a sticky fault flag.

Parameters:
- NUM_STAGES, 4, number of power-switch stages (2..8).
- DLY_W, 8, width of cfg_stage_dly and the stage delay counter.
- ISO_DLY, 4, cycles between isolation/clock-enable edges (>=1).
- TIMEOUT, 255, cycles allowed for pg_ack[k] to rise after stage k delay expires.

Ports:
- nvdla_core_clk, input, 1, block clock.
- nvdla_core_rst, input, 1, asynchronous active-high reset.
- pwr_req, input, 1, level; 1 = island requested on, 0 = requested off.
- pwr_ack, output, 1, level; 1 only when the island is fully on and de-isolated.
- cfg_stage_dly, input, DLY_W, cycles between stage enables; sampled at sequence start; 0 is treated as 1.
- pg_en, output, NUM_STAGES, power-switch stage enables (1 = switch on).
- pg_ack, input, NUM_STAGES, per-stage switch acknowledge from the AND chain; pre-synchronised.
- iso_en, output, 1, island output isolation (1 = isolated).
- clk_en, output, 1, island clock enable.
- busy, output, 1, sequence in progress (not OFF, not ON, not FAULT).
- fault, output, 1, sticky ack timeout.

Behaviour:
- Reset values: pg_en=0, iso_en=1, clk_en=0, pwr_ack=0, busy=0, fault=0, state=OFF. All outputs are registered. Reset mid-sequence returns immediately to these values.
- States: OFF, UP_STG, UP_WAIT, CLK_ON, ISO_REL, ON, ISO_SET, CLK_OFF, DN_STG, FAULT. Stage index k has width clog2(NUM_STAGES).
- OFF, pwr_req=1 → UP_STG:
  - k=0, latch dly = max(cfg_stage_dly, 1).
  - Assert pg_en[0] on the next cycle.
- UP_STG: count dly cycles from the pg_en[k] rising edge, then → UP_WAIT.
- UP_WAIT: wait for pg_ack[k]=1.
  - If k<NUM_STAGES-1: k++, set pg_en[k], → UP_STG.
  - If k=NUM_STAGES-1: → CLK_ON.
  - If pg_ack[k] is still 0 after TIMEOUT cycles: → FAULT.
- CLK_ON: clk_en=1, wait ISO_DLY cycles → ISO_REL.
- ISO_REL: iso_en=0, wait ISO_DLY cycles → ON.
- ON: pwr_ack=1.
- ON, pwr_req=0 → ISO_SET:
  - pwr_ack drops on the next edge.
  - iso_en=1, wait ISO_DLY cycles → CLK_OFF.
- CLK_OFF: clk_en=0, wait ISO_DLY cycles → DN_STG with k=NUM_STAGES-1.
- DN_STG:
  - Clear pg_en[k], wait dly cycles.
  - If k>0: k--, repeat. If k=0: → OFF.
  - pg_ack is not checked on power-down.
- Minimum up latency (pwr_req rise to pwr_ack): NUM_STAGES*(dly+1) + 2*ISO_DLY + 1 cycles, with pg_ack immediate.
- Request reversal mid-sequence: no abort. The current sequence completes, then pwr_req is re-evaluated in ON/OFF. A pulse shorter than the full sequence therefore still produces a complete up or down sequence.
- pwr_req toggling in ON/OFF without a settled sequence is handled by level only; no edge detection.
- FAULT:
  - Holds pg_en, clk_en=0, iso_en=1, pwr_ack=0, fault=1, busy=0.
  - pwr_req is ignored. Exit is by reset only.
- pg_en is thermometer-coded at all times: bits [k:0] set, never holes.
- Delay and timeout counters saturate and never wrap.
- cfg_stage_dly changes mid-sequence have no effect until the next sequence.

Decomposition:
- Package nv_pwr_pkg: state enum (10 states, 4-bit encoding), stage index width function, ISO_DLY/TIMEOUT defaults.
- Sub-module nv_pwr_dly_cnt: loadable down-counter with a done flag and saturation at 0. Two instances: the stage/iso delay counter and the ack timeout counter.

Test Plan:
- Nominal up: reset, cfg_stage_dly=3, pg_ack mirrors pg_en one cycle later, pwr_req=1.
  - pg_en steps 0001→0011→0111→1111, 4–5 cycles apart.
  - clk_en rises, then iso_en falls after 4 cycles.
  - pwr_ack=1 at the computed latency ±1.
- Nominal down from ON, pwr_req=0:
  - pwr_ack=0 next cycle, iso_en=1, clk_en=0 after 4 cycles.
  - pg_en 1111→0111→0011→0001→0000 every 3 cycles; busy=0 in OFF.
- Timeout: pg_ack[2] stuck 0.
  - fault=1 exactly TIMEOUT cycles after the stage-2 delay expires.
  - pg_en=0111, iso_en=1, clk_en=0.
  - pwr_req toggles are ignored until reset.
- Reversal: drop pwr_req while pg_en=0011.
  - Up sequence completes and pwr_ack pulses for ≥1 cycle.
  - Down sequence follows; final pg_en=0000.
- Mid-sequence async reset at pg_en=0111: all outputs go to reset values immediately, without waiting for a clock edge. A new pwr_req restarts from stage 0.
- cfg_stage_dly=0: treated as 1; stages are 2 cycles apart, with no hang.
